// File: rtl/alu_issue_sequencer_if.sv
// Instruction handshake and register-file/ALU control bundle for alu_issue_sequencer.
// The master drives instructions and returns the ALU result; the slave is the sequencer.
interface alu_issue_sequencer_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 3
);
    logic [11:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] rf_raddr1;
    logic [ADDR_W-1:0] rf_raddr2;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              busy;
    logic              done;
    logic [15:0]       retired;

    modport master (
        output instr, instr_valid, alu_result,
        input  instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
               alu_op, busy, done, retired
    );

    modport slave (
        input  instr, instr_valid, alu_result,
        output instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
               alu_op, busy, done, retired
    );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Single-clock sequencer: preloads the register file, then runs each accepted
// instruction through READ -> EXEC -> WB with one write-back per instruction.
module alu_issue_sequencer #(
    parameter int unsigned       DATA_W    = 12,
    parameter int unsigned       ADDR_W    = 3,
    parameter logic [DATA_W-1:0] INIT_BASE = DATA_W'(3),
    parameter bit                INIT_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    alu_issue_sequencer_if.slave bus
);
    localparam int unsigned NREGS = 2 ** ADDR_W;
    localparam int unsigned IDX_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [11:0]       r_instr;
    logic              r_ready;
    logic              r_busy;
    logic              r_we;
    logic              r_done;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [15:0]       r_retired;
    logic              w_accept;

    assign w_accept = (r_state == S_IDLE) && r_ready && bus.instr_valid;

    // Read addresses and opcode come straight from the latched instruction, so they
    // hold their last values through IDLE and WB.
    assign bus.alu_op      = r_instr[11:9];
    assign bus.rf_raddr1   = ADDR_W'(r_instr[5:3]);
    assign bus.rf_raddr2   = ADDR_W'(r_instr[2:0]);
    assign bus.instr_ready = r_ready;
    assign bus.busy        = r_busy;
    assign bus.rf_we       = r_we;
    assign bus.rf_waddr    = r_waddr;
    assign bus.rf_wdata    = r_wdata;
    assign bus.done        = r_done;
    assign bus.retired     = r_retired;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= INIT_EN ? S_INIT : S_IDLE;
            r_idx     <= '0;
            r_instr   <= '0;
            r_ready   <= 1'b0;
            r_busy    <= INIT_EN;
            r_we      <= 1'b0;
            r_done    <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_retired <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                // r_idx == NREGS is a drain step so the last preload write stays one cycle wide
                S_INIT: begin
                    if (r_idx == IDX_W'(NREGS)) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_we    <= 1'b1;
                        r_waddr <= ADDR_W'(r_idx);
                        r_wdata <= INIT_BASE + DATA_W'(r_idx);
                        r_idx   <= r_idx + IDX_W'(1);
                    end
                end
                S_IDLE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    if (w_accept) begin
                        r_instr <= bus.instr;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_EXEC;
                end
                // Capture the settled ALU result directly into the write-data register
                S_EXEC: begin
                    r_we    <= 1'b1;
                    r_done  <= 1'b1;
                    r_waddr <= ADDR_W'(r_instr[8:6]);
                    r_wdata <= bus.alu_result;
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_retired <= r_retired + 16'd1;
                    r_ready   <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Scoreboard bench for alu_issue_sequencer: register file and ALU live here, a
// reference model predicts every register write and a monitor checks them.
module tb_alu_issue_sequencer;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned ADDR_W = 3;
    localparam logic [11:0] BASE   = 12'd3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_issue_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if1 ();
    alu_issue_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if2 ();

    alu_issue_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_BASE(BASE), .INIT_EN(1'b1))
        dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    alu_issue_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_BASE(BASE), .INIT_EN(1'b0))
        dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_we2    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bench-side ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1 a, 6 SHR1 a, 7 NOT b
    function automatic logic [11:0] alu_f(input logic [2:0] op, input logic [11:0] a,
                                          input logic [11:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return {a[10:0], 1'b0};
            3'd6:    return {1'b0, a[11:1]};
            default: return ~b;
        endcase
    endfunction

    logic [11:0] rf1 [8];
    logic [11:0] rf2 [8];

    assign if1.alu_result = alu_f(if1.alu_op, rf1[if1.rf_raddr1], rf1[if1.rf_raddr2]);
    assign if2.alu_result = alu_f(if2.alu_op, rf2[if2.rf_raddr1], rf2[if2.rf_raddr2]);

    // dut2 has no preload, so its register file gets a known pattern on reset instead
    always @(posedge clk) begin
        if (if1.rf_we) rf1[if1.rf_waddr] <= if1.rf_wdata;
        if (reset) begin
            for (int i = 0; i < 8; i++) rf2[i] <= 12'(100 * i + 7);
        end else if (if2.rf_we) begin
            rf2[if2.rf_waddr] <= if2.rf_wdata;
        end
    end

    typedef struct {
        int addr;
        int data;
        bit wb;
        int cyc;
    } exp_t;

    exp_t        q [$];
    logic [11:0] model [8];
    int          exp_retired = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every register write must match the oldest predicted write
    always @(negedge clk) begin : monitor
        exp_t e;
        if (if1.rf_we) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h (cycle %0d)",
                         if1.rf_waddr, if1.rf_wdata, cyc);
            end else begin
                e = q.pop_front();
                check("wr_addr", 32'(if1.rf_waddr), e.addr);
                check("wr_data", 32'(if1.rf_wdata), e.data);
                check("wr_done", 32'(if1.done), 32'(e.wb));
                check("wr_cycle", cyc, e.cyc);
            end
        end else if (if1.done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_without_write: done=1 rf_we=0 (cycle %0d)", cyc);
        end
        if (if2.rf_we) n_we2++;
    end

    task automatic push_preload(input int n);
        q.delete();
        for (int i = 0; i < 8; i++) begin
            model[i] = BASE + 12'(i);
            q.push_back('{i, int'(model[i]), 1'b0, n + 1 + i});
        end
    endtask

    task automatic do_reset(input int ncyc);
        reset = 1'b1;
        if1.instr_valid = 1'b0;
        repeat (ncyc) @(negedge clk);
        check("rst_ready", 32'(if1.instr_ready), 0);
        check("rst_we", 32'(if1.rf_we), 0);
        check("rst_done", 32'(if1.done), 0);
        check("rst_retired", 32'(if1.retired), 0);
        check("rst_busy", 32'(if1.busy), 1);
        check("rst_addr", {if1.rf_raddr1, if1.rf_raddr2, if1.rf_waddr, if1.alu_op}, 0);
        check("rst_wdata", 32'(if1.rf_wdata), 0);
        check("rst_busy_noinit", 32'(if2.busy), 0);
        reset = 1'b0;
        push_preload(cyc);
        exp_retired = 0;
    endtask

    // Offer ins until accepted; while ready is low the bus carries junk that must be ignored
    task automatic issue(input logic [11:0] ins, input bit hold, input bit exp_wb, output int acc);
        int k;
        logic [11:0] r;
        k = 0;
        if1.instr_valid = 1'b1;
        while (!if1.instr_ready && k < 40) begin
            if1.instr = 12'($urandom);
            @(negedge clk);
            k++;
        end
        if (!if1.instr_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: instr_ready stayed 0 (cycle %0d)", cyc);
            if1.instr_valid = 1'b0;
            acc = -1;
            return;
        end
        if1.instr = ins;
        acc = cyc;
        if (exp_wb) begin
            r = alu_f(ins[11:9], model[ins[5:3]], model[ins[2:0]]);
            q.push_back('{int'(ins[8:6]), int'(r), 1'b1, cyc + 3});
            model[ins[8:6]] = r;
            exp_retired++;
        end
        @(negedge clk);
        check("read_ready_low", 32'(if1.instr_ready), 0);
        check("read_raddr1", 32'(if1.rf_raddr1), 32'(ins[5:3]));
        check("read_raddr2", 32'(if1.rf_raddr2), 32'(ins[2:0]));
        check("read_alu_op", 32'(if1.alu_op), 32'(ins[11:9]));
        if (!hold) if1.instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(q.size() == 0 && if1.instr_ready) && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (!(q.size() == 0 && if1.instr_ready)) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: %0d writes outstanding, ready=%0d", q.size(),
                     if1.instr_ready);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int a1, a2, a3, acc, prev_acc;
        bit hold, prev_hold;
        logic [11:0] ins;

        if1.instr = '0;
        if1.instr_valid = 1'b0;
        if2.instr = '0;
        if2.instr_valid = 1'b0;

        // Reset and preload timing
        do_reset(2);
        @(negedge clk);
        check("noinit_ready_cycle1", 32'(if2.instr_ready), 1);
        check("noinit_busy", 32'(if2.busy), 0);
        repeat (7) @(negedge clk);
        check("preload_ready_low_c8", 32'(if1.instr_ready), 0);
        @(negedge clk);
        check("preload_ready_c9", 32'(if1.instr_ready), 1);
        check("preload_busy_c9", 32'(if1.busy), 0);
        check("preload_retired", 32'(if1.retired), 0);
        check("preload_queue_drained", q.size(), 0);
        check("noinit_no_writes", n_we2, 0);

        // Single ADD: reg0 = reg1 + reg2 = 4 + 5
        issue({3'd0, 3'd0, 3'd1, 3'd2}, 1'b0, 1'b1, acc);
        wait_idle();
        check("add_reg0", 32'(rf1[0]), 9);
        check("add_retired", 32'(if1.retired), 1);

        // Valid held high across three instructions; the second consumes reg0
        issue({3'd2, 3'd5, 3'd6, 3'd7}, 1'b1, 1'b1, a1);
        issue({3'd0, 3'd3, 3'd0, 3'd1}, 1'b1, 1'b1, a2);
        issue({3'd1, 3'd6, 3'd3, 3'd0}, 1'b0, 1'b1, a3);
        check("b2b_spacing_1", a2 - a1, 4);
        check("b2b_spacing_2", a3 - a2, 4);
        wait_idle();
        check("b2b_reg3", 32'(rf1[3]), 13);
        check("b2b_reg6", 32'(rf1[6]), 4);
        check("b2b_retired", 32'(if1.retired), 4);

        // Reset while the instruction sits in EXEC: no write, preload reruns
        issue({3'd0, 3'd7, 3'd1, 3'd2}, 1'b0, 1'b0, acc);
        @(negedge clk);
        do_reset(2);
        wait_idle();
        check("abort_reg0_restored", 32'(rf1[0]), 3);
        check("abort_retired", 32'(if1.retired), 0);

        // Counter wrap from a forced 0xFFFF
        @(negedge clk);
        force dut1.r_retired = 16'hFFFF;
        @(negedge clk);
        release dut1.r_retired;
        @(negedge clk);
        check("wrap_preset", 32'(if1.retired), 32'hFFFF);
        issue({3'd4, 3'd2, 3'd4, 3'd5}, 1'b0, 1'b1, acc);
        wait_idle();
        check("wrap_retired", 32'(if1.retired), 0);
        exp_retired = 0;

        // Sequencer without preload: one instruction, 107 + 207
        if2.instr = {3'd0, 3'd4, 3'd1, 3'd2};
        if2.instr_valid = 1'b1;
        check("noinit_ready_idle", 32'(if2.instr_ready), 1);
        @(negedge clk);
        if2.instr_valid = 1'b0;
        if2.instr = 12'hFFF;
        check("noinit_raddr1", 32'(if2.rf_raddr1), 1);
        @(negedge clk);
        check("noinit_exec_no_we", 32'(if2.rf_we), 0);
        @(negedge clk);
        check("noinit_wb_we", 32'(if2.rf_we), 1);
        check("noinit_wb_done", 32'(if2.done), 1);
        check("noinit_wb_addr", 32'(if2.rf_waddr), 4);
        check("noinit_wb_data", 32'(if2.rf_wdata), 314);
        @(negedge clk);
        check("noinit_we_pulse", 32'(if2.rf_we), 0);
        check("noinit_retired", 32'(if2.retired), 1);
        check("noinit_ready_again", 32'(if2.instr_ready), 1);
        check("noinit_write_count", n_we2, 1);

        // Random traffic with random gaps and held-valid bursts
        prev_hold = 1'b0;
        prev_acc = -1;
        for (int i = 0; i < 40; i++) begin
            ins = 12'($urandom);
            hold = 1'($urandom_range(0, 1));
            issue(ins, hold, 1'b1, acc);
            if (prev_hold && prev_acc >= 0 && acc >= 0) check("rand_spacing", acc - prev_acc, 4);
            prev_hold = hold;
            prev_acc = acc;
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        if1.instr_valid = 1'b0;
        wait_idle();
        check("rand_retired", 32'(if1.retired), 32'(16'(exp_retired)));
        for (int i = 0; i < 8; i++) check("rand_regfile", 32'(rf1[i]), 32'(model[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
